seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle radix-2 restoring divider for the RV32M divide group (DIV, DIVU, REM, REMU). It is the iterative counterpart to the single-cycle multiply/divide unit. It removes the 32-bit combinational divide from the execute path and returns one 32-bit result per request through a start/busy/done handshake. It sits beside the ALU in execute; the control unit stalls the pipeline while busy is high.

## Interface
Parameters:
- none (fixed 32-bit datapath, funct3 encodings from defines.v: `F3_DIV`=3'b100, `F3_DIVU`=3'b101, `F3_REM`=3'b110, `F3_REMU`=3'b111)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only when idle
- type  in  3  funct3 of the request; captured with start
- a  in  32  dividend (rs1); captured with start
- b  in  32  divisor (rs2); captured with start
- busy  out  1  high from the cycle after acceptance until done is asserted
- done  out  1  single-cycle pulse; r is valid in that cycle
- r  out  32  result; holds its value until the next done

## Operation
- States: IDLE, DIV, FIX.
- Acceptance: in IDLE, start=1 and type[2]=1 is accepted. start is ignored while busy, or when type[2]=0 (multiply encodings); no state change and no done in those cases.
- On acceptance:
  - Latch type.
  - Form |a| and |b| for signed types, raw values for unsigned.
  - Record the quotient sign (sign a XOR sign b) and the remainder sign (sign a).
  - Clear the remainder register and load a 6-bit iteration counter with 0.
- Fast paths, taken at acceptance by going directly to FIX:
  - b==0: quotient=0xFFFFFFFF, remainder=a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- DIV state, one iteration per cycle, 32 iterations:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor magnitude using a 33-bit subtract.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set 0.
  - After counter=31, go to FIX.
- FIX state, one cycle:
  - Negate the quotient if the quotient sign is set (signed types only).
  - Negate the remainder if the dividend was negative (signed types only).
  - Select the quotient for DIV/DIVU and the remainder for REM/REMU.
  - Write r, pulse done, return to IDLE.
- Widths: magnitudes are 32-bit unsigned; |0x80000000| = 0x80000000 is handled correctly by the unsigned datapath.
- Reset values: busy=0, done=0, r=0, state=IDLE, counter=0.

## Timing
- Normal latency: start sampled at edge E0. busy is high after E0. Iterations occur at E1..E32, FIX at E33. done=1 and r valid in the cycle after E33; busy falls at E33.
- Fast-path latency: start at E0, FIX at E1; done in the cycle after E1.
- done is asserted for exactly one cycle. r is stable from done until the next done.
- A start that is high in the same cycle as done (state IDLE) is accepted; back-to-back operations therefore need no gap cycle.
- Operands may change after the acceptance edge without effect.
- Reset mid-operation: rst_n low asynchronously forces IDLE with busy=0, done=0, r=0. The aborted operation produces no done after rst_n is released.

## Test plan
- DIVU a=100, b=7 -> done exactly 33 cycles after the start edge, r=14; repeat with REMU -> r=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> r=0xFFFFFFFD (-3); REM same operands -> r=0xFFFFFFFF (-1); REM a=7, b=0xFFFFFFFE -> r=1.
- Divide by zero: DIVU a=5, b=0 -> r=0xFFFFFFFF with done one cycle after acceptance; REM a=0xFFFFFFFB, b=0 -> r=0xFFFFFFFB.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> r=0x80000000 (fast path); REM same -> r=0.
- Handshake:
  - Pulse start with new operands at cycle 10 of a DIVU 0xFFFFFFFF/1 -> ignored; first result r=0xFFFFFFFF.
  - start with type=3'b000 in IDLE -> busy stays 0, no done.
  - start asserted during done -> second operation accepted with correct result.
- Reset mid-operation: drop rst_n at iteration 15 -> busy=0, done=0, r=0 immediately. Release rst_n, then run DIVU 0x12345678/0x10 -> r=0x01234567 with normal latency.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider for the RV32M divide
// group (DIV, DIVU, REM, REMU). One request is accepted through a
// start/busy/done handshake; a normal division takes 32 iteration cycles plus
// one sign-fix cycle, while divide-by-zero and signed overflow skip straight
// to the fix cycle.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request strobe, sampled only while idle
//   op_type  in   3   funct3 of the request (the spec's "type", which is a
//                     reserved word); only 3'b1xx encodings are accepted
//   a        in  32   dividend (rs1), captured with start
//   b        in  32   divisor (rs2), captured with start
//   busy     out  1   high from the cycle after acceptance until done
//   done     out  1   single-cycle pulse, r valid in that cycle
//   r        out 32   result, held until the next done
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] r
);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t      state_q, state_d;
  logic [2:0]  type_q;
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] quo_q;      // dividend bits shift out the top, quotient bits in
  logic [31:0] dvs_q;      // divisor magnitude
  logic [5:0]  cnt_q;
  logic        q_neg_q;    // negate quotient in FIX
  logic        r_neg_q;    // negate remainder in FIX

  // Request decode and operand conditioning (used only on the accept edge).
  logic        accept;
  logic        is_signed;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, overflow;

  assign accept    = (state_q == IDLE) && start && op_type[2];
  assign is_signed = ~op_type[0];   // DIV=100, REM=110
  assign a_mag     = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign b_mag     = (is_signed && b[31]) ? (32'd0 - b) : b;
  assign div_zero  = (b == 32'd0);
  assign overflow  = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // One restoring step: shift the next dividend bit into the remainder and
  // trial-subtract with one extra bit so the borrow shows up in bit 32.
  // When the trial goes negative the shifted remainder is below the divisor,
  // so it fits in 32 bits and the dropped rem_q[31] is known to be zero.
  logic [32:0] trial;
  logic        fits;

  assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
  assign fits  = ~trial[32];

  // Sign fix-up and result select.
  logic [31:0] q_fix, r_fix;

  assign q_fix = q_neg_q ? (32'd0 - quo_q) : quo_q;
  assign r_fix = r_neg_q ? (32'd0 - rem_q) : rem_q;

  assign busy = (state_q != IDLE);

  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // so no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (div_zero || overflow) ? FIX : DIV;
      DIV:  if (cnt_q == 6'd31) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q  <= 3'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 6'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      done    <= 1'b0;
      r       <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            type_q <= op_type;
            dvs_q  <= b_mag;
            cnt_q  <= 6'd0;
            if (div_zero) begin
              // Raw results; the fix cycle must leave them untouched.
              quo_q   <= 32'hFFFF_FFFF;
              rem_q   <= a;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
            end else if (overflow) begin
              quo_q   <= 32'h8000_0000;
              rem_q   <= 32'd0;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= 32'd0;
              q_neg_q <= is_signed && (a[31] ^ b[31]);
              r_neg_q <= is_signed && a[31];
            end
          end
        end
        DIV: begin
          rem_q <= fits ? trial[31:0] : {rem_q[30:0], quo_q[31]};
          quo_q <= {quo_q[30:0], fits};
          cnt_q <= cnt_q + 6'd1;
        end
        FIX: begin
          r    <= type_q[1] ? r_fix : q_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider. A driver issues directed requests and
// pushes the hand-computed result and latency into a scoreboard queue; an
// independent monitor pops and compares on every done pulse and checks that
// r holds its value between results.
module tb_seq_divider;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op_type;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] r;

  seq_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_type (op_type),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .r       (r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] r;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hold_r = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one request at the current time (caller is at a negedge), let the
  // next rising edge sample it, then scramble the operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] er, input int lat, input string nm,
                       input bit expect_acc);
    exp_t e;
    start   = 1'b1;
    op_type = op;
    a       = aa;
    b       = bb;
    @(posedge clk);
    #1;
    if (expect_acc) begin
      e.r    = er;
      e.lat  = lat;
      e.acc  = cyc;
      e.name = nm;
      sb.push_back(e);
    end
    start   = 1'b0;
    op_type = 3'b000;
    a       = ~aa;
    b       = ~bb;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [31:0] er, input int lat, input string nm);
    @(negedge clk);
    issue(op, aa, bb, er, lat, nm, 1'b1);
    drain();
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          if (sb.size() == 0) begin
            check("spurious_done", {31'd0, done}, 32'd0);
          end else begin
            e = sb.pop_front();
            check({e.name, "_r"}, r, e.r);
            check({e.name, "_lat"}, cyc - e.acc, e.lat);
            hold_r = e.r;
          end
        end else begin
          check("r_hold", r, hold_r);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b0;
    op_type = 3'b000;
    a       = 32'd0;
    b       = 32'd0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal divisions
    run(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    run(F3_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    run(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    run(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run(F3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");

    // Fast paths
    run(F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run(F3_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "rem_by0");
    run(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    // start while busy is ignored
    @(negedge clk);
    issue(F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_busy", 1'b1);
    repeat (9) @(negedge clk);
    check("busy_mid", {31'd0, busy}, 32'd1);
    issue(F3_DIVU, 32'd10, 32'd2, 32'd0, 0, "ignored", 1'b0);
    drain();

    // Multiply encoding is not accepted
    @(negedge clk);
    issue(3'b000, 32'd6, 32'd7, 32'd0, 0, "mul", 1'b0);
    check("mul_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("mul_busy_later", {31'd0, busy}, 32'd0);

    // Back-to-back: second start coincides with done
    @(negedge clk);
    issue(F3_DIVU, 32'd1000, 32'd10, 32'd100, 33, "b2b_first", 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    check("b2b_done_seen", {31'd0, done}, 32'd1);
    issue(F3_REMU, 32'd1000, 32'd33, 32'd10, 33, "b2b_second", 1'b1);
    drain();

    // Reset in the middle of an operation
    @(negedge clk);
    issue(F3_DIVU, 32'hFFFF_0000, 32'd3, 32'd0, 0, "aborted", 1'b0);
    repeat (15) @(negedge clk);
    #2;
    hold_r = 32'd0;
    rst_n  = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_r", r, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run(F3_DIVU, 32'h1234_5678, 32'h10, 32'h0123_4567, 33, "divu_after_rst");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
